d7s_scan_decoder: RTL and testbench

D7S_SCAN_DECODER -- requirements
Module: d7s_scan_decoder

---
 rtl/d7s_scan_decoder.sv | 152 +++++++++++++++
 tb/tb_d7s_scan_decoder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d7s_scan_decoder.sv
// d7s_scan_decoder: captures a 3-digit multiplexed 7-segment scan into BCD frames.
// Define D7S_SCAN_HEX_EN to also decode the A-F segment patterns as hex digits.
module d7s_scan_decoder #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  transistor_in,
  input  logic [6:0]  seg_in,
  output logic [11:0] digit_bcd,
  output logic [2:0]  digit_err,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        overrun,
  output logic        timeout
);

  localparam logic [7:0]  CAP_CNT  = 8'(STABLE_CYC - 2);
  localparam logic [7:0]  SAT_CNT  = 8'(STABLE_CYC - 1);
  localparam logic [19:0] IDLE_MAX = 20'(TIMEOUT_CYC - 1);

  logic [2:0]  t_s1, t_s2, t_prev;
  logic [6:0]  s_s1, s_s2, s_prev;
  logic [7:0]  stab_cnt;
  logic [19:0] idle_cnt;
  logic [11:0] slot_bcd;
  logic [2:0]  slot_err;
  logic [2:0]  cap_flag;
  logic        one_hot;
  logic        same;
  logic        cap;
  logic        full;
  logic        hit;
  logic [3:0]  dec_val;
  logic        dec_err;

  assign one_hot = (t_s2 == 3'b001) ||
                   (t_s2 == 3'b010) ||
                   (t_s2 == 3'b100);
  assign same = ({t_s2, s_s2} == {t_prev, s_prev});
  assign cap  = one_hot && same && (stab_cnt == CAP_CNT);
  assign full = &cap_flag;
  assign hit  = (|cap_flag) && !full &&
                (idle_cnt == IDLE_MAX);

  // Two-flop synchronizers plus the previous synchronized sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_s1   <= '0;
      t_s2   <= '0;
      t_prev <= '0;
      s_s1   <= '0;
      s_s2   <= '0;
      s_prev <= '0;
    end else begin
      t_s1   <= transistor_in;
      t_s2   <= t_s1;
      t_prev <= t_s2;
      s_s1   <= seg_in;
      s_s2   <= s_s1;
      s_prev <= s_s2;
    end
  end

  // Stability counter, saturates once a digit is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (!(one_hot && same)) begin
      stab_cnt <= '0;
    end else if (stab_cnt != SAT_CNT) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // Segment pattern to digit lookup.
  always_comb begin
    dec_val = 4'hF;
    dec_err = 1'b0;
    unique case (s_s2)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
`ifdef D7S_SCAN_HEX_EN
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
`endif
      default: dec_err = 1'b1;
    endcase
  end

  // Slot capture, captured flags, idle timer and timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_bcd <= '0;
      slot_err <= '0;
      cap_flag <= '0;
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= hit;
      if (full || hit) begin
        cap_flag <= cap ? t_s2 : 3'b000;
      end else if (cap) begin
        cap_flag <= cap_flag | t_s2;
      end
      if (cap || hit || (cap_flag == 3'b000)) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 20'd1;
      end
      for (int i = 0; i < 3; i++) begin
        if (cap && t_s2[i]) begin
          slot_bcd[4*i +: 4] <= dec_val;
          slot_err[i]        <= dec_err;
        end
      end
    end
  end

  // Frame output register with valid/ready and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_bcd   <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (full) begin
      digit_bcd   <= slot_bcd;
      digit_err   <= slot_err;
      frame_valid <= 1'b1;
      if (frame_valid && !frame_ready) begin
        overrun <= 1'b1;
      end
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_d7s_scan_decoder.sv
// tb_d7s_scan_decoder: directed vector table plus randomized scan
// checked against a cycle-level behavioural model.
module tb_d7s_scan_decoder;

  localparam int S  = 4;
  localparam int TB = 16;

  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  tr;
  logic [6:0]  sg;
  logic        ready;

  logic [11:0] bcd_a, bcd_b;
  logic [2:0]  err_a, err_b;
  logic        fv_a, fv_b;
  logic        ov_a, ov_b;
  logic        to_a, to_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fva_n = 0;
  int fvb_n = 0;
  int tob_n = 0;
  int tob_first = -1;

  // behavioural model of the TIMEOUT_CYC=16 instance
  logic [9:0]  m_p1, m_p2, m_last;
  int          m_run;
  int          m_e = 0;
  int          m_lastcap = 0;
  logic [2:0]  m_flags;
  logic [3:0]  m_sb [3];
  logic [2:0]  m_se;
  logic [11:0] m_bcd;
  logic [2:0]  m_err;
  logic        m_fv, m_ov, m_to;

  typedef struct {
    logic [6:0]  s0;
    logic [6:0]  s1;
    logic [6:0]  s2;
    logic [11:0] bcd;
    logic [2:0]  err;
  } vec_t;

  vec_t vt [7];

  always #5 clk = ~clk;

  d7s_scan_decoder #(
    .STABLE_CYC(S)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .transistor_in(tr),
    .seg_in(sg),
    .digit_bcd(bcd_a),
    .digit_err(err_a),
    .frame_valid(fv_a),
    .frame_ready(ready),
    .overrun(ov_a),
    .timeout(to_a)
  );

  d7s_scan_decoder #(
    .STABLE_CYC(S),
    .TIMEOUT_CYC(TB)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .transistor_in(tr),
    .seg_in(sg),
    .digit_bcd(bcd_b),
    .digit_err(err_b),
    .frame_valid(fv_b),
    .frame_ready(ready),
    .overrun(ov_b),
    .timeout(to_b)
  );

  function automatic logic [4:0] mdec(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (s == PAT[i]) return {1'b0, 4'(i)};
`ifdef D7S_SCAN_HEX_EN
    for (int i = 10; i < 16; i++)
      if (s == PAT[i]) return {1'b0, 4'(i)};
`endif
    return 5'h1F;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [9:0] v;
    logic       cap, full, hit;
    logic [4:0] d;
    int         idx;
    m_e++;
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_last = '0;
      m_run = 1; m_flags = '0; m_se = '0;
      for (int i = 0; i < 3; i++) m_sb[i] = '0;
      m_bcd = '0; m_err = '0;
      m_fv = 0; m_ov = 0; m_to = 0;
      return;
    end
    v = m_p2;
    m_p2 = m_p1;
    m_p1 = {tr, sg};
    if (v == m_last) m_run++;
    else m_run = 1;
    m_last = v;
    cap = ($countones(v[9:7]) == 1) && (m_run == S);
    d = mdec(v[6:0]);
    idx = v[8] ? 1 : (v[9] ? 2 : 0);
    full = (m_flags == 3'b111);
    hit = (m_flags != 0) && !full &&
          ((m_e - m_lastcap) == TB);
    m_to = hit;
    if (full) begin
      if (m_fv && !ready) m_ov = 1;
      m_fv = 1;
      m_bcd = {m_sb[2], m_sb[1], m_sb[0]};
      m_err = m_se;
    end else if (m_fv && ready) begin
      m_fv = 0;
    end
    if (full || hit) m_flags = '0;
    if (cap) begin
      m_flags[idx] = 1'b1;
      m_sb[idx] = d[3:0];
      m_se[idx] = d[4];
      m_lastcap = m_e;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (fv_a) fva_n++;
    if (fv_b) fvb_n++;
    if (to_b) begin
      tob_n++;
      if (tob_first < 0) tob_first = cyc;
    end
  endtask

  task automatic hold(input logic [2:0] t,
                      input logic [6:0] s,
                      input int n);
    tr = t;
    sg = s;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [6:0] s0,
                            input logic [6:0] s1,
                            input logic [6:0] s2);
    hold(3'b001, s0, 20);
    hold(3'b010, s1, 20);
    hold(3'b100, s2, 20);
    hold(3'b000, 7'h00, 6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tr = '0;
    sg = '0;
    repeat (3) step();
    chk("reset_a", {bcd_a, err_a, fv_a, ov_a, to_a}, 0);
    chk("reset_b", {bcd_b, err_b, fv_b, ov_b, to_b}, 0);
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    int left;
    rst = 1'b1;
    tr = '0;
    sg = '0;
    ready = 1'b1;

    vt[0] = '{7'h06, 7'h5B, 7'h4F, 12'h321, 3'b000};
    vt[1] = '{7'h3F, 7'h7F, 7'h6F, 12'h980, 3'b000};
    vt[2] = '{7'h66, 7'h6D, 7'h7D, 12'h654, 3'b000};
    vt[3] = '{7'h5B, 7'h07, 7'h7D, 12'h672, 3'b000};
`ifdef D7S_SCAN_HEX_EN
    vt[4] = '{7'h06, 7'h77, 7'h4F, 12'h3A1, 3'b000};
    vt[5] = '{7'h07, 7'h00, 7'h77, 12'hAF7, 3'b010};
    vt[6] = '{7'h79, 7'h71, 7'h7F, 12'h8FE, 3'b000};
`else
    vt[4] = '{7'h06, 7'h77, 7'h4F, 12'h3F1, 3'b010};
    vt[5] = '{7'h07, 7'h00, 7'h77, 12'hFF7, 3'b110};
    vt[6] = '{7'h79, 7'h71, 7'h7F, 12'h8FF, 3'b011};
`endif

    // decode table, one frame per vector
    do_reset();
    for (int i = 0; i < 7; i++) begin
      fva_n = 0;
      send_frame(vt[i].s0, vt[i].s1, vt[i].s2);
      chk($sformatf("vec%0d_bcd", i), bcd_a, vt[i].bcd);
      chk($sformatf("vec%0d_err", i), err_a, vt[i].err);
      chk($sformatf("vec%0d_pulse", i), fva_n, 1);
    end

    // continuous scan, one pulse per frame
    fva_n = 0;
    repeat (3) begin
      hold(3'b001, 7'h06, 20);
      hold(3'b010, 7'h5B, 20);
      hold(3'b100, 7'h4F, 20);
    end
    hold(3'b000, 7'h00, 6);
    chk("scan_pulses", fva_n, 3);
    chk("scan_bcd", bcd_a, 12'h321);
    chk("scan_err", err_a, 3'b000);

    // stability threshold
    do_reset();
    fva_n = 0;
    hold(3'b001, 7'h06, S - 1);
    hold(3'b000, 7'h00, 5);
    hold(3'b010, 7'h5B, 20);
    hold(3'b100, 7'h4F, 20);
    hold(3'b000, 7'h00, 6);
    chk("short_hold_nocap", fva_n, 0);
    hold(3'b001, 7'h3F, S);
    hold(3'b000, 7'h00, 8);
    chk("exact_hold_pulse", fva_n, 1);
    chk("exact_hold_bcd", bcd_a, 12'h320);

    // overrun with consumer stalled
    do_reset();
    ready = 1'b0;
    send_frame(7'h06, 7'h5B, 7'h4F);
    chk("stall1_fv", fv_a, 1);
    chk("stall1_bcd", bcd_a, 12'h321);
    chk("stall1_ov", ov_a, 0);
    send_frame(7'h66, 7'h6D, 7'h7D);
    chk("stall2_fv", fv_a, 1);
    chk("stall2_bcd", bcd_a, 12'h654);
    chk("stall2_ov", ov_a, 1);
    ready = 1'b1;
    step();
    chk("accept_fv", fv_a, 0);
    chk("accept_ov", ov_a, 1);
    chk("accept_bcd", bcd_a, 12'h654);

    // partial frame timeout on the short-timeout instance
    do_reset();
    tob_n = 0;
    tob_first = -1;
    c0 = cyc;
    hold(3'b001, 7'h06, 6);
    hold(3'b000, 7'h00, 30);
    chk("timeout_lat", tob_first - c0, 2 + S + TB);
    chk("timeout_width", tob_n, 1);
    fvb_n = 0;
    hold(3'b010, 7'h5B, 8);
    hold(3'b100, 7'h4F, 8);
    hold(3'b000, 7'h00, 24);
    chk("timeout_noframe", fvb_n, 0);

    // reset mid-frame discards everything
    do_reset();
    ready = 1'b0;
    send_frame(7'h06, 7'h5B, 7'h4F);
    chk("pre_rst_fv", fv_a, 1);
    hold(3'b001, 7'h06, 8);
    hold(3'b010, 7'h5B, 8);
    rst = 1'b1;
    tr = '0;
    sg = '0;
    step();
    chk("in_rst_out",
        {bcd_a, err_a, fv_a, ov_a, to_a}, 0);
    repeat (2) step();
    rst = 1'b0;
    ready = 1'b1;
    fva_n = 0;
    hold(3'b100, 7'h4F, 8);
    hold(3'b000, 7'h00, 20);
    chk("post_rst_noframe", fva_n, 0);
    chk("post_rst_fv", fv_a, 0);

    // randomized scan against the model
    do_reset();
    left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (left == 0) begin
        int r;
        int k;
        r = $urandom_range(0, 9);
        if (r < 7) tr = 3'(1 << $urandom_range(0, 2));
        else if (r == 7) tr = 3'b000;
        else tr = 3'($urandom_range(3, 7));
        k = $urandom_range(0, 19);
        if (k < 16) sg = PAT[k];
        else sg = 7'($urandom);
        left = $urandom_range(1, 9);
      end
      left--;
      ready = ($urandom_range(0, 3) != 0);
      step();
      chk("rand",
          {bcd_b, err_b, fv_b, ov_b, to_b},
          {m_bcd, m_err, m_fv, m_ov, m_to});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
